// File: rtl/imem_responder.sv
// Instruction-memory responder: word-addressed preloadable RAM answering core fetches after LATENCY cycles.
// Optional feature: define IMEM_BOUNDS_CHECK_EN to flag misaligned / out-of-window fetches with an ebreak.
module imem_responder #(
    parameter int          AW      = 10,
    parameter logic [31:0] BASE    = 32'h80000000,
    parameter int          LATENCY = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [31:0]   req_addr,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_inst,
    output logic          rsp_err,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data
);

    localparam logic [31:0] EBREAK   = 32'h00100073;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [31:0] addr_q;
    logic        accept, enter_resp, handshake;
    logic [31:0] rd_addr, rd_off;
    logic [AW-1:0] rd_idx;
    logic        rd_err;

    logic [31:0] mem [0:(1<<AW)-1];

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        req_ready  = 1'b0;
        accept     = 1'b0;
        enter_resp = 1'b0;
        handshake  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept  = 1'b1;
                    cnt_nxt = CNT_INIT;
                    if (LATENCY == 1) begin
                        state_nxt  = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nxt  = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    handshake = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // With LATENCY==1 the read happens on the accept edge, so use the live address.
    assign rd_addr = (state == IDLE) ? req_addr : addr_q;
    assign rd_off  = rd_addr - BASE;
    assign rd_idx  = rd_off[AW+1:2];

`ifdef IMEM_BOUNDS_CHECK_EN
    assign rd_err = (rd_addr[1:0] != 2'b00) || (rd_off[31:AW+2] != '0);
`else
    logic unused_off_bits;
    assign unused_off_bits = ^{rd_off[31:AW+2], rd_off[1:0]};
    assign rd_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_inst  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (enter_resp) begin
                rsp_valid <= 1'b1;
                rsp_inst  <= rd_err ? EBREAK : mem[rd_idx];
                rsp_err   <= rd_err;
            end else if (handshake) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) addr_q <= req_addr;
    end

    // Preload port is live in every state, reset included; same-edge reads see the old word.
    always_ff @(posedge clk) begin
        if (load_en) mem[load_addr] <= load_data;
    end

endmodule
